pc_sequencer: RTL

Multi-cycle fetch/execute sequencer for the one-cycle core. It owns the PC, the Z/L/G flags register and the instruction-fetch handshake, and resolves branches from the decoded jump strobes. It emits exec_en so that the decoded reg_write, dm_write_enable and flags_write strobes take effect only in the execute cycle.

---
 rtl/pc_seq_pkg.sv | 40 ++++
 rtl/branch_unit.sv | 34 +++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared definitions for the fetch/execute sequencer.
//   - sequencer state encoding (3 bits)
//   - bit positions of Z/L/G inside the packed flags vector
//   - branch opcode values, kept here so the decoder and sequencer agree
//   - packed struct bundling the decoded branch strobes
package pc_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_HALTED = 3'd3;
  localparam logic [2:0] ST_FAULT  = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    FETCH  = ST_FETCH,
    EXEC   = ST_EXEC,
    HALTED = ST_HALTED,
    FAULT  = ST_FAULT
  } state_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_L = 1;
  localparam int FLAG_G = 2;

  localparam logic [4:0] OP_JZ   = 5'hD;
  localparam logic [4:0] OP_JNZ  = 5'hE;
  localparam logic [4:0] OP_JG   = 5'hF;
  localparam logic [4:0] OP_JL   = 5'h10;
  localparam logic [4:0] OP_JUMP = 5'h11;

  typedef struct packed {
    logic jump;
    logic jz;
    logic jnz;
    logic jg;
    logic jl;
  } br_strobe_t;

endpackage

// File: rtl/branch_unit.sv
// branch_unit: combinational next-PC resolver.
//   strobe      - decoded branch strobes (jump/jz/jnz/jg/jl)
//   flags       - registered Z/L/G flags (value before the current EXEC edge)
//   pc          - current instruction address
//   jump_target - branch destination from the instruction
//   next_pc     - jump_target when taken, else pc+1 (wraps)
//   taken       - branch decision
module branch_unit
  import pc_seq_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  br_strobe_t          strobe,
  input  logic [2:0]          flags,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                taken
);

  // The highest-priority asserted strobe alone decides; a lower strobe never
  // rescues a not-taken higher one.
  always_comb begin
    taken = 1'b0;
    if (strobe.jump)     taken = 1'b1;
    else if (strobe.jz)  taken = flags[FLAG_Z];
    else if (strobe.jnz) taken = ~flags[FLAG_Z];
    else if (strobe.jg)  taken = flags[FLAG_G];
    else if (strobe.jl)  taken = flags[FLAG_L];
  end

  assign next_pc = taken ? jump_target : pc + 1'b1;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute sequencer.
// Owns the PC, the Z/L/G flags and the retired count; runs the instruction
// fetch handshake and gates decoded write strobes through exec_en.
//   clk, rst_n            - clock, async active-low reset
//   run, halt_req         - start/resume level, stop-after-current level
//   fetch_req / fetch_ack - instruction fetch handshake (pc stable in FETCH)
//   pc                    - current instruction address
//   exec_en               - one-cycle pulse per instruction (EXEC)
//   flags_write, alu_*    - flag update inputs, used only in EXEC
//   is_*, jump_target     - decoded branch strobes and destination
//   flag_z/l/g            - registered flags
//   retired               - retired-instruction count (wraps)
//   halted, fault         - status; fault is sticky until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                  PC_WIDTH      = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
  parameter int                  FETCH_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                halt_req,
  output logic                fetch_req,
  input  logic                fetch_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic                exec_en,
  input  logic                flags_write,
  input  logic                alu_zero,
  input  logic                alu_less,
  input  logic                is_jz,
  input  logic                is_jnz,
  input  logic                is_jl,
  input  logic                is_jg,
  input  logic                is_jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic                flag_z,
  output logic                flag_l,
  output logic                flag_g,
  output logic [15:0]         retired,
  output logic                halted,
  output logic                fault
);

  localparam logic [7:0] TO_LIM = 8'(FETCH_TIMEOUT);

  state_t              state, state_nxt;
  logic [2:0]          flags;
  logic [7:0]          to_cnt;
  logic [7:0]          to_cnt_inc;
  logic [PC_WIDTH-1:0] next_pc;
  logic                taken;
  br_strobe_t          strobe;

  assign strobe = '{jump: is_jump, jz: is_jz, jnz: is_jnz, jg: is_jg, jl: is_jl};

  branch_unit #(.PC_WIDTH(PC_WIDTH)) u_br (
    .strobe      (strobe),
    .flags       (flags),
    .pc          (pc),
    .jump_target (jump_target),
    .next_pc     (next_pc),
    .taken       (taken)
  );

  assign to_cnt_inc = to_cnt + 8'd1;

  // Next state. An ack in the cycle the timeout is reached takes priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (run && !halt_req) state_nxt = FETCH;
      FETCH: begin
        if (fetch_ack)                 state_nxt = EXEC;
        else if (to_cnt_inc == TO_LIM) state_nxt = FAULT;
      end
      EXEC:   state_nxt = halt_req ? HALTED : FETCH;
      HALTED: if (run && !halt_req) state_nxt = FETCH;
      FAULT:  state_nxt = FAULT;
      default: state_nxt = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Timeout counter only advances while waiting in FETCH; any other path
  // (ack, fault, leaving FETCH) restarts it from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                        to_cnt <= '0;
    else if (state == FETCH && state_nxt == FETCH)     to_cnt <= to_cnt_inc;
    else                                               to_cnt <= '0;
  end

  // Architectural state commits only on the closing edge of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      flags   <= '0;
      retired <= '0;
    end else if (state == EXEC) begin
      pc      <= next_pc;
      retired <= retired + 16'd1;
      if (flags_write) begin
        flags[FLAG_Z] <= alu_zero;
        flags[FLAG_L] <= alu_less;
        flags[FLAG_G] <= ~alu_zero & ~alu_less;
      end
    end
  end

  assign fetch_req = (state == FETCH);
  assign exec_en   = (state == EXEC);
  assign halted    = (state == HALTED);
  assign fault     = (state == FAULT);
  assign flag_z    = flags[FLAG_Z];
  assign flag_l    = flags[FLAG_L];
  assign flag_g    = flags[FLAG_G];

endmodule
